sp_ram_dma: RTL and testbench

- Memory-port initiator that drives a single-port word RAM (en/addr/wdata/we/be request, registered 1-cycle read data).
- Performs word-block copy (read then write within the same RAM) or word-block fill on a start command from a control FSM or CPU-side register block.
- Sits between a control register block and the RAM instance; owns the RAM port exclusively while busy.

---
 rtl/sp_ram_dma.sv | 168 ++++++++++++++++
 tb/tb_sp_ram_dma.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_dma.sv
// sp_ram_dma: memory-port initiator for a single-port word RAM.
// Copies a block of words within the same RAM (read then write) or fills a
// block with a constant pattern. The RAM port belongs to this block while busy.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             command strobe, sampled only while idle
//   mode_i              0 = copy, 1 = fill
//   src_addr_i          copy source byte address (bits [1:0] ignored)
//   dst_addr_i          destination byte address (bits [1:0] ignored)
//   len_i               word count (0 completes with no RAM access)
//   fill_data_i         fill pattern
//   busy_o, done_o      status: busy while transferring, one-cycle done pulse
//   mem_*               RAM request port; mem_rdata_i valid one cycle after a read
//   csum_o              XOR of all written words (only with SP_RAM_DMA_CSUM_EN)
//
// Optional feature macro: SP_RAM_DMA_CSUM_EN adds the csum_o write checksum.
module sp_ram_dma #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [31:0]           fill_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i
`ifdef SP_RAM_DMA_CSUM_EN
  ,
  output logic [31:0]           csum_o
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] FILL = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [31:0]           fill_q;
  logic                  accept;

  // A command is taken only from IDLE; starts elsewhere are dropped.
  assign accept = (state_q == IDLE) && start_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM port / status decode; the RAM port is driven straight
  // from state and registers so the request leaves in the same cycle.
  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == LEN_ZERO) begin
            state_d = DONE;
          end else if (mode_i) begin
            state_d = FILL;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        busy_o     = 1'b1;
        mem_en_o   = 1'b1;
        mem_addr_o = src_q;
        state_d    = WR;
      end
      WR: begin
        // Read data returned for the preceding RD is written straight back.
        busy_o      = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = dst_q;
        mem_wdata_o = mem_rdata_i;
        state_d     = (count_q == LEN_ONE) ? DONE : RD;
      end
      FILL: begin
        busy_o      = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = 4'hF;
        mem_addr_o  = dst_q;
        mem_wdata_o = fill_q;
        state_d     = (count_q == LEN_ONE) ? DONE : FILL;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command capture and address/count stepping; addresses wrap modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
    end else if (accept) begin
      src_q   <= src_addr_i & WORD_MASK;
      dst_q   <= dst_addr_i & WORD_MASK;
      count_q <= len_i;
      fill_q  <= fill_data_i;
    end else if (state_q == WR) begin
      src_q   <= src_q + WORD_STEP;
      dst_q   <= dst_q + WORD_STEP;
      count_q <= count_q - LEN_ONE;
    end else if (state_q == FILL) begin
      dst_q   <= dst_q + WORD_STEP;
      count_q <= count_q - LEN_ONE;
    end
  end

`ifdef SP_RAM_DMA_CSUM_EN
  // Running XOR of every written word; holds after completion until next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_o <= '0;
    end else if (accept) begin
      csum_o <= '0;
    end else if (mem_we_o) begin
      csum_o <= csum_o ^ mem_wdata_o;
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram_dma.sv
// Self-checking bench for sp_ram_dma: RAM model with operation log plus a
// word-level reference model of copy/fill commands.
module tb_sp_ram_dma;

  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = 6;
  localparam int unsigned WORDS = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic [31:0]   fill_data = '0;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata = '0;
`ifdef SP_RAM_DMA_CSUM_EN
  logic [31:0]   csum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_ram_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .len_i       (len),
    .fill_data_i (fill_data),
    .busy_o      (busy),
    .done_o      (done),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
`ifdef SP_RAM_DMA_CSUM_EN
    ,
    .csum_o      (csum)
`endif
  );

  // RAM model: registered read, byte enables checked, every access logged.
  logic [31:0] ram     [WORDS];
  logic [31:0] ref_ram [WORDS];
  logic [6:0]  ops[$];
  int          port_err = 0;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_idx] <= pre_data;
    end else if (mem_en) begin
      if (mem_be !== (mem_we ? 4'hF : 4'h0) || mem_addr[1:0] !== 2'b00) port_err <= port_err + 1;
      ops.push_back({mem_we, mem_addr[7:2]});
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[7:2]];
    end else if (mem_we !== 1'b0 || mem_be !== 4'h0) begin
      port_err <= port_err + 1;
    end
  end

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 6'(idx); pre_data = data;
    ref_ram[idx] = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Compare whole RAM against the reference model.
  task automatic check_ram(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < int'(WORDS); i++)
      if (ram[i] !== ref_ram[i]) begin bad++; if (first < 0) first = i; end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s ram: %0d words differ, first word %0d got %h want %h",
               name, bad, first, ram[first], ref_ram[first]);
    end
  endtask

  // Issue one command, compare against the word-level model.
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int n, input logic [31:0] f, input int poke_at,
                         input string name);
    logic [6:0]  exp_ops[$];
    logic [31:0] exp_csum = 0;
    int sw = int'(s) / 4;
    int dw = int'(d) / 4;
    int lat_exp, en_exp, k, busy_n, en_n, be0, bad;
    logic got;
    // Reference model: strictly forward word-by-word transfer.
    for (int i = 0; i < n; i++) begin
      int si = (sw + i) % int'(WORDS);
      int di = (dw + i) % int'(WORDS);
      logic [31:0] v = m ? f : ref_ram[si];
      if (!m) exp_ops.push_back({1'b0, 6'(si)});
      exp_ops.push_back({1'b1, 6'(di)});
      ref_ram[di] = v;
      exp_csum ^= v;
    end
    lat_exp = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
    en_exp  = m ? n : 2 * n;

    @(negedge clk);
    ops.delete();
    be0 = port_err;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = LW'(n); fill_data = f;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs so only captured values can be used.
    mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
    len = LW'($urandom); fill_data = $urandom;
    k = 1; busy_n = 0; en_n = 0; got = 1'b0;
    while (k <= 400) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      if (busy === 1'b1) busy_n++;
      if (mem_en === 1'b1) en_n++;
      start = (k == poke_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;

    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL %s timeout: no done within 400 cycles", name);
    end
    n_cmp++;
    if (k != lat_exp) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, k, lat_exp);
    end
    n_cmp++;
    if (busy_n != lat_exp - 1 || en_n != en_exp) begin
      n_err++; $display("FAIL %s busy/en cycles: got %0d/%0d want %0d/%0d",
                        name, busy_n, en_n, lat_exp - 1, en_exp);
    end
    n_cmp++;
    if (mem_en !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s done cycle: en=%b busy=%b want 0/0", name, mem_en, busy);
    end
    bad = (ops.size() != exp_ops.size()) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < exp_ops.size(); i++) if (ops[i] !== exp_ops[i]) bad = 1;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL %s op trace: got %0d ops want %0d (first got %h want %h)",
                        name, ops.size(), exp_ops.size(),
                        (ops.size() > 0) ? ops[0] : 7'h0,
                        (exp_ops.size() > 0) ? exp_ops[0] : 7'h0);
    end
    n_cmp++;
    if (port_err != be0) begin
      n_err++; $display("FAIL %s port encoding: %0d bad be/addr cycles want 0", name, port_err - be0);
    end
    // Pulse lasts one cycle; no extra command from a start seen while busy.
    for (int i = 0; i < ((poke_at > 0) ? 2 * n + 4 : 1); i++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL %s after done +%0d: done=%b busy=%b want 0/0", name, i + 1, done, busy);
      end
    end
`ifdef SP_RAM_DMA_CSUM_EN
    n_cmp++;
    if (csum !== exp_csum) begin
      n_err++; $display("FAIL %s csum: got %h want %h", name, csum, exp_csum);
    end
`endif
    check_ram(name);
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({busy, done, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: busy=%b done=%b en=%b we=%b be=%h addr=%h wdata=%h want all 0",
               name, busy, done, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
`ifdef SP_RAM_DMA_CSUM_EN
    n_cmp++;
    if (csum !== 32'h0) begin
      n_err++; $display("FAIL %s csum: got %h want 0", name, csum);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) preload(i, $urandom);
    @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_fill();
    run_cmd(1'b1, 8'h10, 8'h10, 4, 32'hA5A5_1234, 0, "fill4");
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));
    run_cmd(1'b0, 8'h00, 8'h40, 4, 32'h0, 0, "copy4");
    n_cmp++;
    if (ram[16] !== 32'd1 || ram[19] !== 32'd4) begin
      n_err++; $display("FAIL copy4 dest words: got %h..%h want 1..4", ram[16], ram[19]);
    end
  endtask

  task automatic test_boundaries();
    run_cmd(1'b1, 8'h00, 8'h20, 0, 32'hFFFF_FFFF, 0, "len0");
    run_cmd(1'b1, 8'h00, 8'hFC, 2, 32'h1357_9BDF, 0, "wrap_fill");
    preload(5, 32'h5555_0005);
    run_cmd(1'b0, 8'hF8, 8'h0C, 3, 32'h0, 0, "wrap_copy");
    preload(0, 32'hCAFE_0000);
    run_cmd(1'b0, 8'h03, 8'h80, 1, 32'h0, 0, "src_unaligned");
    run_cmd(1'b1, 8'h00, 8'h37, 63, 32'h0F0F_F0F0, 0, "max_len_fill");
  endtask

  task automatic test_overlap_ignored_start();
    preload(0, 32'h0000_DEAD);
    run_cmd(1'b0, 8'h00, 8'h04, 3, 32'h0, 2, "overlap");
    n_cmp++;
    if (ram[1] !== 32'hDEAD || ram[2] !== 32'hDEAD || ram[3] !== 32'hDEAD) begin
      n_err++; $display("FAIL overlap words1..3: got %h %h %h want 0000dead", ram[1], ram[2], ram[3]);
    end
    run_cmd(1'b0, 8'h20, 8'h20, 3, 32'h0, 0, "same_src_dst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      logic m = 1'($urandom);
      int n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      run_cmd(m, AW'($urandom), AW'($urandom), n, $urandom, 0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 8; i++) preload(i, 32'h1111_0000 + 32'(i));
    @(negedge clk);
    start = 1'b1; mode = 1'b1; src_addr = '0; dst_addr = 8'h00; len = LW'(8);
    fill_data = 32'hBEEF_0008;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ref_ram[0] = 32'hBEEF_0008;
    ref_ram[1] = 32'hBEEF_0008;
    #1;
    check_outputs_zero("reset_mid_fill");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_ram("reset_mid_fill");
    run_cmd(1'b1, 8'h40, 8'h40, 2, 32'h0246_8ACE, 0, "fill_after_reset");
  endtask

`ifdef SP_RAM_DMA_CSUM_EN
  task automatic test_csum();
    run_cmd(1'b1, 8'h00, 8'h60, 3, 32'h0000_00FF, 0, "csum_fill");
    for (int i = 1; i < 4; i++) preload(i, 32'(i));
    run_cmd(1'b0, 8'h04, 8'hA0, 3, 32'h0, 0, "csum_copy");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (csum !== 32'h0) begin
      n_err++; $display("FAIL csum_hold: got %h want 0", csum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_boundaries();
    test_overlap_ignored_start();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef SP_RAM_DMA_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
